// File: rtl/spi_slave_fsm_if.sv
// SPI slave transaction-controller bus: conditioned SPI inputs plus data-memory and MISO signals.
// Latency: none (signal bundle only).
// Backpressure: none; the controller paces itself on the SCLK edge pulses.
interface spi_slave_fsm_if #(
   parameter int DATAWIDTH = 8,
   parameter int ADDRWIDTH = 7
);
   logic                 cs_cond;
   logic                 sclk_pos;
   logic                 sclk_neg;
   logic                 mosi_cond;
   logic [DATAWIDTH-1:0] dm_rdata;
   logic [ADDRWIDTH-1:0] dm_addr;
   logic [DATAWIDTH-1:0] dm_wdata;
   logic                 dm_we;
   logic                 miso_q;
   logic                 miso_oe;

   // The transaction controller itself
   modport slave (
      input  cs_cond, sclk_pos, sclk_neg, mosi_cond, dm_rdata,
      output dm_addr, dm_wdata, dm_we, miso_q, miso_oe
   );

   // Conditioners and data memory driving the controller
   modport master (
      output cs_cond, sclk_pos, sclk_neg, mosi_cond, dm_rdata,
      input  dm_addr, dm_wdata, dm_we, miso_q, miso_oe
   );
endinterface

// File: rtl/spi_slave_fsm.sv
// SPI memory-slave transaction controller: address/RW byte then one data byte, MSB first.
// Latency: dm_addr valid 2 clk after the 8th address rise; dm_we 1 clk after the 8th data rise.
// Backpressure: none; the SPI master paces all shifts, and CS high aborts any transaction.
module spi_slave_fsm #(
   parameter int DATAWIDTH = 8,
   parameter int ADDRWIDTH = 7
) (
   input  logic              clk,
   input  logic              reset,
   spi_slave_fsm_if.slave    io_bus
);

   localparam int CW = $clog2(DATAWIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_GET_ADDR    = 3'd1,
      S_GOT_ADDR    = 3'd2,
      S_READ_LOAD   = 3'd3,
      S_READ_SHIFT  = 3'd4,
      S_WRITE_SHIFT = 3'd5,
      S_WRITE_MEM   = 3'd6,
      S_DONE        = 3'd7
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [DATAWIDTH-1:0]  r_sr;
   logic [CW-1:0]         r_cnt;
   logic [ADDRWIDTH-1:0]  r_dm_addr;
   logic                  r_miso_q;
   logic                  r_miso_oe;
   logic                  w_dm_we;

   // CS going high ends any transaction and beats every other event this cycle
   logic w_abort;
   logic w_last;
   logic w_shift_in;
   logic w_shift_out;

   assign w_abort     = io_bus.cs_cond && (r_state != S_IDLE);
   assign w_last      = (r_cnt == CW'(DATAWIDTH - 1));
   // Only the edge that matters in the current state acts; the other is ignored
   assign w_shift_in  = !w_abort && io_bus.sclk_pos &&
                        ((r_state == S_GET_ADDR) || (r_state == S_WRITE_SHIFT));
   assign w_shift_out = !w_abort && io_bus.sclk_neg && (r_state == S_READ_SHIFT);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state decode; abort is checked first so an aborted write never reaches WRITE_MEM
   always_comb begin
      w_next = r_state;
      if (w_abort) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:        if (!io_bus.cs_cond)              w_next = S_GET_ADDR;
            S_GET_ADDR:    if (io_bus.sclk_pos && w_last)    w_next = S_GOT_ADDR;
            S_GOT_ADDR:    w_next = r_sr[0] ? S_READ_LOAD : S_WRITE_SHIFT;
            S_READ_LOAD:   w_next = S_READ_SHIFT;
            S_READ_SHIFT:  if (io_bus.sclk_neg && w_last)    w_next = S_DONE;
            S_WRITE_SHIFT: if (io_bus.sclk_pos && w_last)    w_next = S_WRITE_MEM;
            S_WRITE_MEM:   w_next = S_DONE;
            S_DONE:        w_next = S_DONE;
            default:       w_next = S_IDLE;
         endcase
      end
   end

   // Moore output decode: write strobe is purely the WRITE_MEM state
   always_comb begin
      w_dm_we = (r_state == S_WRITE_MEM);
   end

   // Shift register: MOSI shift-in, MISO shift-out, or parallel load of memory read data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sr <= '0;
      end else if (w_shift_in) begin
         r_sr <= {r_sr[DATAWIDTH-2:0], io_bus.mosi_cond};
      end else if (w_shift_out) begin
         r_sr <= {r_sr[DATAWIDTH-2:0], 1'b0};
      end else if ((r_state == S_READ_LOAD) && !w_abort) begin
         r_sr <= io_bus.dm_rdata;
      end
   end

   // Bit counter: cleared between bytes and whenever the transaction is not running
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if ((r_state == S_IDLE) || (r_state == S_GOT_ADDR) || w_abort) begin
         r_cnt <= '0;
      end else if (w_shift_in || w_shift_out) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Address latch: upper bits of the first byte, low bit is the R/W flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dm_addr <= '0;
      end else if ((r_state == S_GOT_ADDR) && !w_abort) begin
         r_dm_addr <= r_sr[DATAWIDTH-1:1];
      end
   end

   // MISO bit register: takes the shift register MSB on each falling SCLK of a read
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_miso_q <= 1'b0;
      end else if (w_shift_out) begin
         r_miso_q <= r_sr[DATAWIDTH-1];
      end
   end

   // MISO enable: on from the read load until CS rises, held through DONE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_miso_oe <= 1'b0;
      end else if (w_abort) begin
         r_miso_oe <= 1'b0;
      end else if (r_state == S_READ_LOAD) begin
         r_miso_oe <= 1'b1;
      end
   end

   assign io_bus.dm_addr  = r_dm_addr;
   assign io_bus.dm_wdata = r_sr;
   assign io_bus.dm_we    = w_dm_we;
   assign io_bus.miso_q   = r_miso_q;
   assign io_bus.miso_oe  = r_miso_oe;

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Directed bench for spi_slave_fsm: write, read, abort, extra edges, mid-read reset, back-to-back.
// Inputs change on the falling clk edge; outputs are sampled on the falling edge.
// SCLK half-period is 4 clk, so every edge pulse is followed by 3 idle cycles.
module tb_spi_slave_fsm;

   logic clk;
   logic reset;

   spi_slave_fsm_if #(.DATAWIDTH(8), .ADDRWIDTH(7)) bus ();

   spi_slave_fsm #(.DATAWIDTH(8), .ADDRWIDTH(7)) dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_fail = 0;

   // Memory model plus write-strobe and MISO-enable activity counters
   logic [7:0] mem [128];
   int         we_cnt;
   int         oe_cycles;
   logic [6:0] last_addr;
   logic [7:0] last_wdata;

   assign bus.dm_rdata = mem[bus.dm_addr];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 128; i++) mem[i] <= 8'hFF;
         we_cnt     <= 0;
         oe_cycles  <= 0;
         last_addr  <= '0;
         last_wdata <= '0;
      end else begin
         if (bus.dm_we) begin
            mem[bus.dm_addr] <= bus.dm_wdata;
            we_cnt           <= we_cnt + 1;
            last_addr        <= bus.dm_addr;
            last_wdata       <= bus.dm_wdata;
         end
         if (bus.miso_oe) oe_cycles <= oe_cycles + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One full SCLK period: rising pulse carrying a MOSI bit, then a falling pulse
   task automatic sclk_cycle(input logic b);
      bus.mosi_cond = b;
      bus.sclk_pos  = 1'b1;
      cyc(1);
      bus.sclk_pos  = 1'b0;
      cyc(3);
      bus.sclk_neg  = 1'b1;
      cyc(1);
      bus.sclk_neg  = 1'b0;
      cyc(3);
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) sclk_cycle(v[i]);
   endtask

   task automatic do_write(input string tag, input logic [6:0] a, input logic [7:0] d);
      int base_we;
      int base_oe;
      base_we = we_cnt;
      base_oe = oe_cycles;
      bus.cs_cond = 1'b0;
      cyc(2);
      send_byte({a, 1'b0});
      send_byte(d);
      cyc(1);
      bus.cs_cond = 1'b1;
      cyc(2);
      check({tag, " we_pulses"},  32'(we_cnt - base_we), 32'd1);
      check({tag, " we_addr"},    32'(last_addr), 32'(a));
      check({tag, " we_data"},    32'(last_wdata), 32'(d));
      check({tag, " mem"},        32'(mem[a]), 32'(d));
      check({tag, " oe_cycles"},  32'(oe_cycles - base_oe), 32'd0);
      check({tag, " state_idle"}, 32'(dut.r_state), 32'd0);
   endtask

   task automatic do_read(input string tag, input logic [6:0] a, input logic [7:0] exp,
                          input int n_extra);
      int base_we;
      base_we = we_cnt;
      bus.cs_cond = 1'b0;
      cyc(2);
      send_byte({a, 1'b1});
      check({tag, " dm_addr"}, 32'(bus.dm_addr), 32'(a));
      check({tag, " oe_on"},   32'(bus.miso_oe), 32'd1);
      check({tag, " miso0"},   32'(bus.miso_q), 32'(exp[7]));
      for (int k = 1; k <= 8; k++) begin
         sclk_cycle(1'b0);
         check($sformatf("%s miso%0d", tag, k), 32'(bus.miso_q),
               32'(exp[(k < 8) ? (7 - k) : 0]));
      end
      for (int e = 0; e < n_extra; e++) begin
         sclk_cycle(1'b1);
         check($sformatf("%s extra%0d miso", tag, e), 32'(bus.miso_q), 32'(exp[0]));
         check($sformatf("%s extra%0d sr", tag, e),   32'(bus.dm_wdata), 32'h00);
         check($sformatf("%s extra%0d oe", tag, e),   32'(bus.miso_oe), 32'd1);
      end
      check({tag, " no_we"}, 32'(we_cnt - base_we), 32'd0);
      bus.cs_cond = 1'b1;
      cyc(1);
      check({tag, " oe_drop"},  32'(bus.miso_oe), 32'd0);
      check({tag, " idle"},     32'(dut.r_state), 32'd0);
      cyc(1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " dm_addr"},  32'(bus.dm_addr), 32'd0);
      check({tag, " dm_wdata"}, 32'(bus.dm_wdata), 32'd0);
      check({tag, " dm_we"},    32'(bus.dm_we), 32'd0);
      check({tag, " miso_q"},   32'(bus.miso_q), 32'd0);
      check({tag, " miso_oe"},  32'(bus.miso_oe), 32'd0);
      check({tag, " state"},    32'(dut.r_state), 32'd0);
   endtask

   // Hard stop in case the sequence ever stalls
   initial begin
      #2000000;
      $display("FAIL watchdog: sequence did not complete");
      $fatal(1);
   end

   initial begin
      int base_we;
      reset         = 1'b1;
      bus.cs_cond   = 1'b1;
      bus.sclk_pos  = 1'b0;
      bus.sclk_neg  = 1'b0;
      bus.mosi_cond = 1'b0;
      cyc(3);
      check_reset_outputs("reset");
      reset = 1'b0;
      cyc(2);
      check("post_reset idle", 32'(dut.r_state), 32'd0);

      // Write 0xA5 to 0x12
      do_write("write", 7'h12, 8'hA5);

      // Read back 0x12 (0xA5), with 3 extra SCLK periods in DONE
      do_read("read", 7'h12, 8'hA5, 3);

      // Abort a write to 0x12 after 5 data bits
      base_we = we_cnt;
      bus.cs_cond = 1'b0;
      cyc(2);
      send_byte(8'h24);
      for (int i = 0; i < 5; i++) sclk_cycle(1'b1);
      bus.cs_cond = 1'b1;
      cyc(1);
      check("abort idle", 32'(dut.r_state), 32'd0);
      check("abort oe",   32'(bus.miso_oe), 32'd0);
      cyc(2);
      check("abort no_we",    32'(we_cnt - base_we), 32'd0);
      check("abort mem_kept", 32'(mem[7'h12]), 32'hA5);
      do_write("after_abort", 7'h7F, 8'h00);

      // Reset in the middle of a read, after 3 MISO bits
      bus.cs_cond = 1'b0;
      cyc(2);
      send_byte(8'h25);
      sclk_cycle(1'b0);
      sclk_cycle(1'b0);
      check("midread miso3", 32'(bus.miso_q), 32'd1);
      check("midread oe",    32'(bus.miso_oe), 32'd1);
      reset = 1'b1;
      cyc(1);
      check_reset_outputs("midreset");
      bus.cs_cond = 1'b1;
      cyc(1);
      reset = 1'b0;
      cyc(2);
      check("midreset idle", 32'(dut.r_state), 32'd0);
      do_write("after_reset", 7'h05, 8'h5A);

      // Back-to-back write then read of the same location
      do_write("b2b_write", 7'h01, 8'h3C);
      do_read("b2b_read", 7'h01, 8'h3C, 0);

      $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
      $finish;
   end

endmodule

// File: doc/spi_slave_fsm.md
# spi_slave_fsm

Transaction controller for the SPI memory slave. It consumes the conditioned chip-select level, the one-cycle SCLK edge pulses and the conditioned MOSI bit produced by the input conditioners. It frames each transaction as an address/R-W byte followed by one data byte, and sequences the internal shift register, the data-memory address latch, the memory write strobe and the MISO output buffer. It sits between the three input conditioners and the data memory / MISO tristate.

## Interface
Parameters:
- datawidth, 8: bits per frame byte and memory word.
- addrwidth, 7: memory address width. Must equal datawidth-1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values.
- cs_cond  in  1  conditioned chip select, active low.
- sclk_pos  in  1  one-cycle pulse on conditioned SCLK rising edge.
- sclk_neg  in  1  one-cycle pulse on conditioned SCLK falling edge.
- mosi_cond  in  1  conditioned MOSI level.
- dm_rdata  in  datawidth  data-memory read data; combinational from dm_addr.
- dm_addr  out  addrwidth  registered memory address.
- dm_wdata  out  datawidth  write data; equals internal shift register.
- dm_we  out  1  memory write strobe, exactly one clk cycle per write transaction.
- miso_q  out  1  registered MISO bit.
- miso_oe  out  1  MISO tristate enable.

## Operation
- Frame format is MSB first. Byte 0 is {addr[addrwidth-1:0], rw}, with rw=1 meaning read. Byte 1 is the data byte, either written via MOSI or read via MISO.
- Internal state: shift register sr[datawidth-1:0], bit counter cnt (wide enough to hold datawidth), FSM state.
- States and transitions:
  - IDLE: cnt=0. If cs_cond=0, go to GET_ADDR.
  - GET_ADDR: on sclk_pos, sr <= {sr[datawidth-2:0], mosi_cond} and cnt++. The 8th shift goes to GOT_ADDR.
  - GOT_ADDR (1 cycle): dm_addr <= sr[datawidth-1:1] and cnt <= 0. Go to READ_LOAD if sr[0]=1, else WRITE_SHIFT.
  - READ_LOAD (1 cycle): sr <= dm_rdata, miso_oe <= 1, go to READ_SHIFT.
  - READ_SHIFT: on sclk_neg, miso_q <= sr[datawidth-1], sr <= sr<<1, cnt++. The 8th shift goes to DONE. sclk_pos is ignored.
  - WRITE_SHIFT: on sclk_pos, shift mosi_cond into sr and cnt++. The 8th shift goes to WRITE_MEM. sclk_neg is ignored.
  - WRITE_MEM (1 cycle): dm_we=1, then go to DONE.
  - DONE: all SCLK edges are ignored. miso_oe and miso_q hold. Wait for cs_cond=1.
- cs_cond=1 in any non-IDLE state:
  - Next state is IDLE and miso_oe <= 0.
  - This has priority over a same-cycle sclk_pos/sclk_neg and over WRITE_MEM, so an aborted write never asserts dm_we.
  - sr, dm_addr and miso_q hold their values.
- dm_we is a Moore decode of state==WRITE_MEM only.
- sclk_pos and sclk_neg asserted in the same cycle is illegal input. If it happens, only the edge relevant to the current state acts.
- Reset values: state=IDLE, sr=0, cnt=0, dm_addr=0, dm_wdata=0, dm_we=0, miso_q=0, miso_oe=0. Reset mid-transaction aborts it with no write. After reset deasserts, the block waits in IDLE. If cs_cond is still 0, it starts GET_ADDR, so the bench must raise CS before retrying.

## Timing
- 8th address sclk_pos in cycle N: GOT_ADDR in N+1, dm_addr valid from N+2, READ_LOAD samples dm_rdata in N+2, miso_oe=1 from N+3.
- The first MISO bit appears in the cycle after the first sclk_neg seen in READ_SHIFT.
- System constraint: SCLK half-period must be at least 4 clk cycles after conditioning, so no sclk_neg arrives before N+3.
- 8th data sclk_pos in cycle M: dm_we high during cycle M+1 only, with dm_wdata and dm_addr stable.
- cs_cond rising in cycle K: state=IDLE and miso_oe=0 from K+1.

## Test plan
- Write: CS low, shift 0x24 (addr 0x12, rw=0), then 0xA5. Expect one dm_we pulse with dm_addr=0x12 and dm_wdata=0xA5, miso_oe=0 throughout.
- Read: memory model returns 0xA5 at 0x12; shift 0x25. Expect miso_oe=1, miso_q sequence 1,0,1,0,0,1,0,1 on successive sclk_neg, and no dm_we.
- Abort: CS raised after 5 data bits of a write. Expect no dm_we, state IDLE. The next full write to 0x7F with data 0x00 then succeeds.
- Extra edges: 3 extra SCLK cycles in DONE after a read. Expect miso_q, sr and dm_we unchanged, and miso_oe to drop one cycle after CS rises.
- Reset mid-read after 3 MISO bits. Expect all outputs at reset values. CS high then low, followed by a fresh write, works normally.
- Back-to-back: write 0x3C to 0x01, CS high for 2 clk, then read 0x01 returning 0x3C. Expect correct sequencing with no state leakage between transactions.
